pixel_seq_ctrl_nmem: RTL and testbench
======================================

Name: pixel_seq_ctrl_nmem

Overview:
- Parametrised next-generation pixel sequencer for SOFIST-type SOI pixel arrays.
- Generates the per-event reset/compare timing: CF_RST, CDS_RST, RST_COMP1/2, COMP_EN and SEL_RST_VTH.
- Stores up to MEM_DEPTH events into in-pixel analog memories through one-hot store strobes.
- Runs an independent readout memory-select pointer.
- Phase lengths are runtime-programmable, and a trigger-driven store mode is included.
- Sits between the register file / readout controller and the pixel array drivers.

Parameters:
MEM_DEPTH, 4, number of in-pixel analog memory cells (2..16)
PTR_W, 4, pointer width, >= clog2(MEM_DEPTH)+1
CNT_W, 8, phase timer width

Ports:
CLK  in  1  system clock
NRST_X  in  1  reset: one clock; reset is asynchronous and active-low
PIX_RESET  in  1  reset/store request, rising-edge sensitive
PIX_STORE  in  1  storage run enable, level
COMP_EN_SEL  in  1  enable COMP_EN during the ARMED state
TRG_MODE  in  1  0: store on PIX_RESET edge; 1: store on TRG_DET
TRG_DET  in  1  trigger detected, level, sampled in ARMED
EVT_NUM_END  in  1  forces end of run after the current store
T_CFRST  in  CNT_W  CF reset phase length, cycles
T_CDS  in  CNT_W  CDS reset phase length, cycles
T_COMP  in  CNT_W  comparator reset skew, cycles
MEM_SET_EN  in  1  advance readout memory, rising-edge sensitive
MEM_SET_CLR  in  1  clear readout pointer, level
READ_MEM  in  PTR_W  number of memories to read out; 0 or >MEM_DEPTH means MEM_DEPTH
REGOUT_EN  in  1  register-output request
CF_RST, CDS_RST, RST_COMP1, RST_COMP2, COMP_EN, SEL_RST_VTH  out  1 each  pixel drive signals
PIX_RESET_BUSY  out  1  high in the CFRST, CDSRST and COMPRST states
STORE_SEL  out  MEM_DEPTH  one-hot store strobe
WR_CNT  out  PTR_W  memories written in the current run
PIX_END  out  1  one-cycle end-of-run pulse
LAST_MEM  out  1  all memories are full; held until the next run starts
RD_SEL  out  MEM_DEPTH  one-hot readout memory select
MEM_SET_DONE  out  1  one-cycle pulse after a readout pointer update
REGOUT_SEL  out  1  REGOUT_EN registered once

Behaviour:
Reset:
- All outputs 0, except RD_SEL = 1 (bit 0).
- WR_CNT = 0; state IDLE.
- An asynchronous reset mid-run aborts immediately; no PIX_END is issued.

Inputs and timers:
- PIX_RESET and MEM_SET_EN edges are detected against a registered copy. The edge is acted on in the cycle after the input rises.
- Timer value 0 is treated as 1.

FSM:
- IDLE: outputs low. On a PIX_RESET edge with PIX_STORE=1, WR_CNT <= 0, LAST_MEM <= 0, go to CFRST.
- CFRST, T_CFRST cycles: CF_RST, CDS_RST, RST_COMP1, RST_COMP2 and SEL_RST_VTH all high.
- CDSRST, T_CDS cycles: CF_RST low; the others stay high.
- COMPRST, T_COMP cycles: CDS_RST and RST_COMP1 low; RST_COMP2 high. Then go to ARMED with RST_COMP2 and SEL_RST_VTH low.
- ARMED: COMP_EN = COMP_EN_SEL, registered. Transitions, highest priority first:
  - PIX_STORE = 0 -> DONE, no store.
  - TRG_MODE = 0 and PIX_RESET edge -> STORE.
  - TRG_MODE = 1 and TRG_DET = 1 -> STORE.
  - TRG_MODE = 1 and PIX_RESET edge -> CFRST (re-reset, no store).
- STORE, 1 cycle:
  - STORE_SEL[WR_CNT] = 1, COMP_EN = 0, WR_CNT++.
  - Go to DONE if the new WR_CNT == MEM_DEPTH, or EVT_NUM_END = 1, or PIX_STORE = 0. Otherwise go to CFRST.
- DONE, 1 cycle: PIX_END = 1. LAST_MEM <= (WR_CNT == MEM_DEPTH). Go to IDLE.

Rules:
- STORE_SEL is never multi-hot. It never addresses an index >= MEM_DEPTH.

Readout side (independent of the FSM):
- MEM_SET_CLR=1: RD_SEL <= bit0; MEM_SET_DONE pulses on the next cycle. CLR has priority over a simultaneous EN edge.
- MEM_SET_EN edge: RD_SEL rotates to the next bit. After the last readable memory (READ_MEM, clamped) it wraps to bit0. MEM_SET_DONE pulses one cycle after the RD_SEL update.
- REGOUT_SEL follows REGOUT_EN with 1-cycle latency.

Test Plan:
1. T_CFRST=4, T_CDS=8, T_COMP=2, TRG_MODE=0, PIX_STORE=1, one PIX_RESET edge -> CF_RST high 4 cycles, CDS_RST 12, RST_COMP1 12, RST_COMP2 14; PIX_RESET_BUSY 14 cycles; then ARMED.
2. Four further PIX_RESET edges with MEM_DEPTH=4 -> STORE_SEL 0001, 0010, 0100, 1000, each followed by a fresh reset sequence, except after the fourth, which goes to DONE. PIX_END one pulse; LAST_MEM=1; WR_CNT=4.
3. PIX_STORE dropped in ARMED after 2 stores -> PIX_END pulse, no further store, LAST_MEM=0, WR_CNT=2. COMP_EN_SEL=1 -> COMP_EN high only in ARMED.
4. TRG_MODE=1: PIX_RESET edge in ARMED -> reset sequence repeats with STORE_SEL=0. TRG_DET=1 -> store in bit0. EVT_NUM_END=1 at the second store -> DONE with WR_CNT=2.
5. READ_MEM=3, six MEM_SET_EN edges -> RD_SEL 010, 100, 001, 010, 100, 001, each with a MEM_SET_DONE pulse. MEM_SET_CLR together with an EN edge -> RD_SEL=0001.
6. NRST_X low during CDSRST -> all drives 0 immediately, no PIX_END; a restart after reset gives a full sequence.

Source files
------------

// File: rtl/pixel_seq_ctrl_nmem.sv
`timescale 1ns/1ps
// pixel_seq_ctrl_nmem: SOFIST pixel reset/compare sequencer with analog-memory store strobes
// and an independent readout memory-select pointer.
module pixel_seq_ctrl_nmem #(
  parameter int MEM_DEPTH = 4,
  parameter int PTR_W = 4,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 nrst_x,
  input  logic                 pix_reset,
  input  logic                 pix_store,
  input  logic                 comp_en_sel,
  input  logic                 trg_mode,
  input  logic                 trg_det,
  input  logic                 evt_num_end,
  input  logic [CNT_W-1:0]     t_cfrst,
  input  logic [CNT_W-1:0]     t_cds,
  input  logic [CNT_W-1:0]     t_comp,
  input  logic                 mem_set_en,
  input  logic                 mem_set_clr,
  input  logic [PTR_W-1:0]     read_mem,
  input  logic                 regout_en,
  output logic                 cf_rst,
  output logic                 cds_rst,
  output logic                 rst_comp1,
  output logic                 rst_comp2,
  output logic                 comp_en,
  output logic                 sel_rst_vth,
  output logic                 pix_reset_busy,
  output logic [MEM_DEPTH-1:0] store_sel,
  output logic [PTR_W-1:0]     wr_cnt,
  output logic                 pix_end,
  output logic                 last_mem,
  output logic [MEM_DEPTH-1:0] rd_sel,
  output logic                 mem_set_done,
  output logic                 regout_sel
);
  typedef enum logic [2:0] {IDLE, CFRST, CDSRST, COMPRST, ARMED, STORE, DONE} state_t;
  state_t state, state_n;
  logic pix_reset_q, mem_set_en_q, rd_upd, pr_edge, ms_edge, t_done, full_n;
  logic [CNT_W-1:0] cnt, t_cur;
  logic [PTR_W-1:0] rd_idx, rd_lim;
  assign pr_edge = pix_reset & ~pix_reset_q;
  assign ms_edge = mem_set_en & ~mem_set_en_q;
  assign t_cur = state == CFRST ? t_cfrst : state == CDSRST ? t_cds : t_comp;
  // a programmed length of 0 behaves as 1
  assign t_done = ({1'b0, cnt} + (CNT_W+1)'(1)) >= {1'b0, t_cur};
  assign full_n = wr_cnt + PTR_W'(1) == PTR_W'(MEM_DEPTH);
  assign rd_lim = (read_mem == '0 || read_mem > PTR_W'(MEM_DEPTH)) ? PTR_W'(MEM_DEPTH) : read_mem;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (pr_edge && pix_store) state_n = CFRST;
      CFRST:   if (t_done) state_n = CDSRST;
      CDSRST:  if (t_done) state_n = COMPRST;
      COMPRST: if (t_done) state_n = ARMED;
      ARMED:   if (!pix_store) state_n = DONE;
               else if (trg_mode ? trg_det : pr_edge) state_n = STORE;
               else if (trg_mode && pr_edge) state_n = CFRST;
      STORE:   state_n = (full_n || evt_num_end || !pix_store) ? DONE : CFRST;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  assign cf_rst = state == CFRST;
  assign cds_rst = state inside {CFRST, CDSRST};
  assign rst_comp1 = state inside {CFRST, CDSRST};
  assign rst_comp2 = state inside {CFRST, CDSRST, COMPRST};
  assign sel_rst_vth = state inside {CFRST, CDSRST, COMPRST};
  assign pix_reset_busy = state inside {CFRST, CDSRST, COMPRST};
  assign pix_end = state == DONE;
  assign store_sel = (state == STORE && wr_cnt < PTR_W'(MEM_DEPTH)) ? MEM_DEPTH'(1) << wr_cnt : '0;
  assign rd_sel = MEM_DEPTH'(1) << rd_idx;
  always_ff @(posedge clk or negedge nrst_x)
    if (!nrst_x) begin
      state <= IDLE;
      cnt <= '0;
      pix_reset_q <= 1'b0;
      wr_cnt <= '0;
      last_mem <= 1'b0;
      comp_en <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= state_n != state ? '0 : cnt + CNT_W'(1);
      pix_reset_q <= pix_reset;
      comp_en <= state_n == ARMED && comp_en_sel;
      if (state == IDLE && state_n == CFRST) begin
        wr_cnt <= '0;
        last_mem <= 1'b0;
      end
      if (state == STORE) wr_cnt <= wr_cnt + PTR_W'(1);
      if (state == DONE) last_mem <= wr_cnt == PTR_W'(MEM_DEPTH);
    end
  always_ff @(posedge clk or negedge nrst_x)
    if (!nrst_x) begin
      rd_idx <= '0;
      mem_set_en_q <= 1'b0;
      rd_upd <= 1'b0;
      mem_set_done <= 1'b0;
      regout_sel <= 1'b0;
    end else begin
      mem_set_en_q <= mem_set_en;
      rd_upd <= mem_set_clr || ms_edge;
      mem_set_done <= rd_upd;
      regout_sel <= regout_en;
      if (mem_set_clr) rd_idx <= '0;
      else if (ms_edge) rd_idx <= rd_idx + PTR_W'(1) >= rd_lim ? '0 : rd_idx + PTR_W'(1);
    end
endmodule

// File: tb/tb_pixel_seq_ctrl_nmem.sv
`timescale 1ns/1ps
// tb_pixel_seq_ctrl_nmem: directed stimulus against a queue-based timeline model of the sequencer.
module tb_pixel_seq_ctrl_nmem;
  localparam int D = 4, PW = 4, CW = 8;
  localparam int P_IDLE = 0, P_SEQ = 1, P_ARM = 2, P_STORE = 3, P_DONE = 4;
  logic clk = 1'b0, nrst_x = 1'b1;
  logic pix_reset = 0, pix_store = 0, comp_en_sel = 0, trg_mode = 0, trg_det = 0, evt_num_end = 0;
  logic [CW-1:0] t_cfrst = 4, t_cds = 8, t_comp = 2;
  logic mem_set_en = 0, mem_set_clr = 0, regout_en = 0;
  logic [PW-1:0] read_mem = 3;
  logic cf_rst, cds_rst, rst_comp1, rst_comp2, comp_en, sel_rst_vth, pix_reset_busy;
  logic pix_end, last_mem, mem_set_done, regout_sel;
  logic [D-1:0] store_sel, rd_sel;
  logic [PW-1:0] wr_cnt;
  always #5 clk = ~clk;
  pixel_seq_ctrl_nmem #(.MEM_DEPTH(D), .PTR_W(PW), .CNT_W(CW)) dut (
    .clk(clk), .nrst_x(nrst_x), .pix_reset(pix_reset), .pix_store(pix_store),
    .comp_en_sel(comp_en_sel), .trg_mode(trg_mode), .trg_det(trg_det), .evt_num_end(evt_num_end),
    .t_cfrst(t_cfrst), .t_cds(t_cds), .t_comp(t_comp), .mem_set_en(mem_set_en),
    .mem_set_clr(mem_set_clr), .read_mem(read_mem), .regout_en(regout_en),
    .cf_rst(cf_rst), .cds_rst(cds_rst), .rst_comp1(rst_comp1), .rst_comp2(rst_comp2),
    .comp_en(comp_en), .sel_rst_vth(sel_rst_vth), .pix_reset_busy(pix_reset_busy),
    .store_sel(store_sel), .wr_cnt(wr_cnt), .pix_end(pix_end), .last_mem(last_mem),
    .rd_sel(rd_sel), .mem_set_done(mem_set_done), .regout_sel(regout_sel));
  int n_tests = 0, n_fail = 0;
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // model: a run is a timeline of drive vectors {cf,cds,comp1,comp2,vth} queued up front
  int ph = P_IDLE, m_wr = 0, m_rd = 0, lim;
  logic [4:0] seq_q[$];
  logic m_last = 0, m_ce = 0, m_pr_q = 0, m_ms_q = 0, m_upd = 0, m_done = 0, m_rg = 0, pe, me;
  task automatic start_seq();
    int a, b, c;
    a = t_cfrst == 0 ? 1 : int'(t_cfrst);
    b = t_cds == 0 ? 1 : int'(t_cds);
    c = t_comp == 0 ? 1 : int'(t_comp);
    seq_q.delete();
    for (int i = 0; i < a + b + c; i++) seq_q.push_back({i < a, i < a + b, i < a + b, 1'b1, 1'b1});
    ph = P_SEQ;
  endtask
  always @(posedge clk or negedge nrst_x) begin
    if (!nrst_x) begin
      ph = P_IDLE; seq_q.delete(); m_wr = 0; m_last = 0; m_ce = 0; m_pr_q = 0;
      m_ms_q = 0; m_upd = 0; m_done = 0; m_rg = 0; m_rd = 0;
    end else begin
      pe = pix_reset && !m_pr_q;
      me = mem_set_en && !m_ms_q;
      case (ph)
        P_IDLE: if (pe && pix_store) begin m_wr = 0; m_last = 0; start_seq(); end
        P_SEQ: begin void'(seq_q.pop_front()); if (seq_q.size() == 0) ph = P_ARM; end
        P_ARM: if (!pix_store) ph = P_DONE;
               else if ((!trg_mode && pe) || (trg_mode && trg_det)) ph = P_STORE;
               else if (trg_mode && pe) start_seq();
        P_STORE: begin m_wr++; if (m_wr == D || evt_num_end || !pix_store) ph = P_DONE; else start_seq(); end
        default: begin m_last = (m_wr == D); ph = P_IDLE; end
      endcase
      m_ce = (ph == P_ARM) && comp_en_sel;
      m_done = m_upd;
      m_upd = mem_set_clr || me;
      lim = (read_mem == 0 || read_mem > D) ? D : int'(read_mem);
      if (mem_set_clr) m_rd = 0; else if (me) m_rd = (m_rd + 1) % lim;
      m_rg = regout_en;
      m_pr_q = pix_reset;
      m_ms_q = mem_set_en;
    end
  end
  int c_cf = 0, c_cds = 0, c_c1 = 0, c_c2 = 0, c_busy = 0, c_pe = 0, c_done = 0, c_ce = 0, c_ce_bad = 0;
  logic [D-1:0] st_hist[$];
  logic [4:0] dv;
  logic [D-1:0] se, re;
  logic [22:0] exp_v, act_v;
  always @(negedge clk) begin
    dv = ph == P_SEQ ? seq_q[0] : 5'b0;
    se = '0;
    if (ph == P_STORE) se[m_wr] = 1'b1;
    re = '0;
    re[m_rd] = 1'b1;
    exp_v = {dv[4], dv[3], dv[2], dv[1], m_ce, dv[0], ph == P_SEQ, se, PW'(m_wr), ph == P_DONE, m_last, re, m_done, m_rg};
    act_v = {cf_rst, cds_rst, rst_comp1, rst_comp2, comp_en, sel_rst_vth, pix_reset_busy, store_sel,
             wr_cnt, pix_end, last_mem, rd_sel, mem_set_done, regout_sel};
    chk("cycle", act_v, exp_v);
    c_cf += int'(cf_rst); c_cds += int'(cds_rst); c_c1 += int'(rst_comp1); c_c2 += int'(rst_comp2);
    c_busy += int'(pix_reset_busy); c_pe += int'(pix_end); c_done += int'(mem_set_done);
    c_ce += int'(comp_en);
    c_ce_bad += int'(comp_en && (pix_reset_busy || store_sel != 0 || pix_end));
    if (store_sel != 0) st_hist.push_back(store_sel);
  end
  int s_cf, s_cds, s_c1, s_c2, s_busy, s_pe, s_done, s_ce, s_bad, s_st;
  task automatic snap();
    s_cf = c_cf; s_cds = c_cds; s_c1 = c_c1; s_c2 = c_c2; s_busy = c_busy; s_pe = c_pe;
    s_done = c_done; s_ce = c_ce; s_bad = c_ce_bad; s_st = st_hist.size();
  endtask
  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask
  task automatic pulse_reset();
    pix_reset = 1; cyc(1); pix_reset = 0; cyc(1);
  endtask
  task automatic ms_edge();
    mem_set_en = 1; cyc(1); mem_set_en = 0; cyc(1);
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "timeout");
  end
  initial begin
    logic [D-1:0] exp_st[4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [D-1:0] exp_rd[6] = '{4'b0010, 4'b0100, 4'b0001, 4'b0010, 4'b0100, 4'b0001};
    logic [D-1:0] exp_rd0[4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    #1 nrst_x = 0;
    #1;
    chk("reset_rd_sel", rd_sel, 1);
    chk("reset_outs", {cf_rst, cds_rst, rst_comp1, rst_comp2, comp_en, sel_rst_vth, pix_reset_busy,
                       store_sel, wr_cnt, pix_end, last_mem, mem_set_done, regout_sel}, 0);
    cyc(3); nrst_x = 1; cyc(2);
    pix_store = 1;
    snap(); pulse_reset(); cyc(20);
    chk("t1_cf_cycles", c_cf - s_cf, 4);
    chk("t1_cds_cycles", c_cds - s_cds, 12);
    chk("t1_comp1_cycles", c_c1 - s_c1, 12);
    chk("t1_comp2_cycles", c_c2 - s_c2, 14);
    chk("t1_busy_cycles", c_busy - s_busy, 14);
    snap();
    for (int i = 0; i < 4; i++) begin pulse_reset(); cyc(20); end
    chk("t2_store_count", st_hist.size() - s_st, 4);
    for (int i = 0; i < 4; i++) if (st_hist.size() > s_st + i) chk("t2_store_sel", st_hist[s_st + i], exp_st[i]);
    chk("t2_pix_end", c_pe - s_pe, 1);
    chk("t2_last_mem", last_mem, 1);
    chk("t2_wr_cnt", wr_cnt, 4);
    chk("t2_busy_cycles", c_busy - s_busy, 42);
    comp_en_sel = 1;
    snap(); pulse_reset(); cyc(20);
    chk("t3_last_cleared", last_mem, 0);
    chk("t3_comp_en_armed", comp_en, 1);
    for (int i = 0; i < 2; i++) begin pulse_reset(); cyc(20); end
    pix_store = 0; cyc(4);
    chk("t3_wr_cnt", wr_cnt, 2);
    chk("t3_last_mem", last_mem, 0);
    chk("t3_pix_end", c_pe - s_pe, 1);
    chk("t3_store_count", st_hist.size() - s_st, 2);
    chk("t3_comp_en_off", comp_en, 0);
    chk("t3_comp_en_only_armed", c_ce_bad - s_bad, 0);
    comp_en_sel = 0; pix_store = 1; trg_mode = 1;
    snap(); pulse_reset(); cyc(20);
    pulse_reset(); cyc(20);
    chk("t4_rereset_no_store", st_hist.size() - s_st, 0);
    chk("t4_rereset_busy", c_busy - s_busy, 28);
    trg_det = 1; cyc(1); trg_det = 0; cyc(20);
    chk("t4_trg_store", st_hist.size() > s_st ? st_hist[s_st] : '0, 4'b0001);
    evt_num_end = 1; trg_det = 1; cyc(1); trg_det = 0; cyc(1); evt_num_end = 0; cyc(4);
    chk("t4_wr_cnt", wr_cnt, 2);
    chk("t4_pix_end", c_pe - s_pe, 1);
    chk("t4_store2", st_hist.size() > s_st + 1 ? st_hist[s_st + 1] : '0, 4'b0010);
    chk("t4_busy", c_busy - s_busy, 42);
    trg_mode = 0;
    snap();
    for (int i = 0; i < 6; i++) begin ms_edge(); chk("t5_rd_sel", rd_sel, exp_rd[i]); end
    cyc(2);
    chk("t5_done_pulses", c_done - s_done, 6);
    ms_edge();
    chk("t5_rd_before_clr", rd_sel, 4'b0010);
    mem_set_en = 1; mem_set_clr = 1; cyc(1); mem_set_en = 0; mem_set_clr = 0; cyc(1);
    chk("t5_clr_priority", rd_sel, 4'b0001);
    cyc(2);
    read_mem = 0;
    for (int i = 0; i < 4; i++) begin ms_edge(); chk("t5_rd_sel_full", rd_sel, exp_rd0[i]); end
    regout_en = 1; cyc(1);
    chk("t5_regout_on", regout_sel, 1);
    regout_en = 0; cyc(1);
    chk("t5_regout_off", regout_sel, 0);
    snap(); pulse_reset(); cyc(6);
    chk("t6_in_cdsrst", {cf_rst, cds_rst}, 2'b01);
    #1 nrst_x = 0;
    #1;
    chk("t6_abort_drives", {cf_rst, cds_rst, rst_comp1, rst_comp2, comp_en, sel_rst_vth, pix_reset_busy, store_sel}, 0);
    cyc(2); nrst_x = 1; cyc(2);
    chk("t6_no_pix_end", c_pe - s_pe, 0);
    chk("t6_wr_cnt", wr_cnt, 0);
    snap(); pulse_reset(); cyc(20);
    chk("t6_restart_busy", c_busy - s_busy, 14);
    chk("t6_restart_cf", c_cf - s_cf, 4);
    pix_store = 0; cyc(4);
    chk("t6_restart_end", c_pe - s_pe, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
